// File: rtl/date_display_pkg.sv
// Shared constants for the date display: stored date table, seven-segment glyphs
// and blank/decimal-point masks.
package date_display_pkg;

   localparam int MAX_DATES  = 16;
   localparam int MAX_DIGITS = 8;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DP    = 8'h80;

   // One BCD nibble per digit, digit 0 in the low nibble (08-21-03 reads 3,0,1,2,8,0).
   localparam logic [31:0] DATE_TABLE [MAX_DATES] = '{
      0:       32'h0008_2103,
      1:       32'h0008_2104,
      2:       32'h0012_3199,
      3:       32'h0001_0100,
      default: 32'h0000_0000
   };

   function automatic logic [7:0] seg_glyph(input logic [3:0] v);
      logic [7:0] g;
      case (v)
         4'h0: g = 8'hC0;
         4'h1: g = 8'hF9;
         4'h2: g = 8'hA4;
         4'h3: g = 8'hB0;
         4'h4: g = 8'h99;
         4'h5: g = 8'h92;
         4'h6: g = 8'h82;
         4'h7: g = 8'hF8;
         4'h8: g = 8'h80;
         4'h9: g = 8'h90;
         4'hA: g = 8'h88;
         4'hB: g = 8'h83;
         4'hC: g = 8'hC6;
         4'hD: g = 8'hA1;
         4'hE: g = 8'h86;
         default: g = 8'h8E;
      endcase
      return g | SEG_DP;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stable-count debouncer and
// a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_press <= 1'b0;
         // Any cycle matching the current level is a bounce and restarts the count.
         if (r_sync[1] != r_level) begin
            if (r_cnt == CW'(DEB_CYCLES - 1)) begin
               r_level <= r_sync[1];
               r_cnt   <= '0;
               r_press <= ~r_sync[1];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/date_display_ctrl.sv
// Switch-to-LED mirror with invert toggle and a selectable stored date on hex digits.
// Optional blink of the hex display is enabled with macro DATE_DISPLAY_BLINK_EN.
module date_display_ctrl
   import date_display_pkg::*;
#(
   parameter int LED_W        = 8,
   parameter int NUM_DIGITS   = 6,
   parameter int NUM_DATES    = 4,
   parameter int DEB_CYCLES   = 500000,
   parameter int BLINK_CYCLES = 12500000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LED_W+1:0]        switch,
   input  logic [1:0]              key,
   output logic [LED_W+1:0]        leds,
   output logic [8*NUM_DIGITS-1:0] hex
);

   localparam int IDX_W = $clog2(NUM_DATES);

   logic [1:0]              w_press;
   logic                    r_invert;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        w_idx_next;
   logic [3:0]              w_sel;
   logic [31:0]             w_date;
   logic                    w_phase;
   logic                    w_blank;
   logic [8*NUM_DIGITS-1:0] w_hex;
   logic [LED_W+1:0]        r_leds;
   logic [8*NUM_DIGITS-1:0] r_hex;

   for (genvar g = 0; g < 2; g++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk     (clk),
         .reset   (reset),
         .i_key_n (key[g]),
         .o_press (w_press[g])
      );
   end

   always_comb begin
      w_idx_next = r_idx;
      if (switch[LED_W])
         w_idx_next = (r_idx == '0) ? IDX_W'(NUM_DATES - 1) : r_idx - 1'b1;
      else
         w_idx_next = (r_idx == IDX_W'(NUM_DATES - 1)) ? '0 : r_idx + 1'b1;
   end

   // Both key events are independent, so a simultaneous press updates both.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_invert <= 1'b0;
         r_idx    <= '0;
      end else begin
         if (w_press[0]) r_invert <= ~r_invert;
         if (w_press[1]) r_idx    <= w_idx_next;
      end
   end

`ifdef DATE_DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_CYCLES);

   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;

   always_ff @(posedge clk) begin
      if (reset || !switch[LED_W+1]) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign w_phase = r_phase;
   assign w_blank = switch[LED_W+1] & r_phase;
`else
   logic w_unused_blink_sw;
   assign w_unused_blink_sw = switch[LED_W+1];
   assign w_phase           = 1'b0;
   assign w_blank           = 1'b0;
`endif

   assign w_sel  = 4'(r_idx);
   assign w_date = DATE_TABLE[w_sel];

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      assign w_hex[8*d +: 8] = w_blank ? SEG_BLANK : seg_glyph(w_date[4*d +: 4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_leds <= '0;
         r_hex  <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         r_leds <= {w_phase, r_invert, switch[LED_W-1:0] ^ {LED_W{r_invert}}};
         r_hex  <= w_hex;
      end
   end

   assign leds = r_leds;
   assign hex  = r_hex;

endmodule

// File: doc/date_display_ctrl.md
DATE_DISPLAY_CTRL -- requirements
Module: date_display_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter LED_W, default 8, SHALL set the number of data LEDs mirrored from switches.
REQ-003 Parameter NUM_DIGITS, default 6, SHALL set the number of seven-segment digits driven.
REQ-004 Parameter NUM_DATES, default 4, SHALL set the number of selectable stored dates (min 2).
REQ-005 Parameter DEB_CYCLES, default 500000, SHALL set the number of stable cycles for debounce acceptance.
REQ-006 Parameter BLINK_CYCLES, default 12500000, SHALL set the blink half-period in cycles.
REQ-007 Port list:
- clk — input, 1 bit: system clock.
- reset — input, 1 bit: synchronous active-high reset.
- switch — input, LED_W+2 bits: slide switches.
- key — input, 2 bits: pushbuttons, active-low (0 = pressed).
- leds — output, LED_W+2 bits: LEDs.
- hex — output, 8*NUM_DIGITS bits: segment outputs. Digit i occupies hex[8i+7:8i]; segments are active-low; bit 7 is the decimal point.

Function
REQ-008 Each key SHALL pass through a 2-flop synchroniser and then a debouncer.
- The debounced level SHALL change only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles.
- Any bounce SHALL restart the count.
REQ-009 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases SHALL generate no event.
REQ-010 A key[0] press event SHALL toggle the invert flag.
REQ-011 A key[1] press event SHALL step the date index:
- +1 when switch[LED_W]=0, -1 when switch[LED_W]=1.
- Wraps NUM_DATES-1 -> 0 on increment and 0 -> NUM_DATES-1 on decrement.
REQ-012 Simultaneous key[0] and key[1] events SHALL both take effect in the same cycle.
REQ-013 A held key SHALL produce exactly one event; there is no auto-repeat.
REQ-014 LED outputs SHALL be registered, so a switch change is visible on leds one cycle later.
- leds[LED_W-1:0] = switch[LED_W-1:0] XOR invert.
- leds[LED_W] = invert.
- leds[LED_W+1] = blink phase (see REQ-020), otherwise 0.
REQ-015 Hex outputs SHALL be registered and show the 4-bit value for each digit of the selected date, with digit 0 as the least significant.
- Values 0-F SHALL use standard hex glyphs.
- The decimal point SHALL be off.
REQ-016 A change to invert or date index SHALL appear on leds/hex on the cycle after the event pulse.

Reset
REQ-017 While reset=1, the block SHALL hold these values; they SHALL take effect at the first clock edge with reset high:
- invert = 0, date index = 0.
- Debounced levels = 1 (released); debounce counters, synchronisers (to 1) and blink counter cleared.
- leds = all 0; hex = all 8'hFF (blank).
REQ-018 Reset mid-debounce or mid-blink SHALL discard partial counts and produce no press event.
REQ-019 The first post-reset update SHALL show date 0 uninverted.

Configuration
REQ-020 With macro DATE_DISPLAY_BLINK_EN defined:
- A free-running counter SHALL toggle a blink phase every BLINK_CYCLES.
- While switch[LED_W+1]=1 and phase=1, all hex digits SHALL be blanked (8'hFF).
- leds[LED_W+1] SHALL show the phase.
- The counter SHALL restart from 0 when switch[LED_W+1] goes 0.
REQ-021 Without DATE_DISPLAY_BLINK_EN:
- switch[LED_W+1] SHALL be ignored.
- leds[LED_W+1] SHALL be 0.
- No blink counter SHALL be synthesised.

Structure
REQ-022 Package date_display_pkg SHALL hold:
- The date table constant (NUM_DATES entries of NUM_DIGITS BCD nibbles; entry 0 = 08-21-03, entry 1 = 08-21-04).
- The segment glyph lookup function.
- Blank and decimal-point constants.
REQ-023 Sub-module key_debounce (synchroniser, counter and edge pulse) SHALL be instantiated once per key.

Verification (bench DEB_CYCLES=4, BLINK_CYCLES=8, default widths)
REQ-024 Reset, then switch=10'h0A5 -> next cycle leds=10'h0A5; hex digits read 3,0,1,2,8,0 (digits 0..5).
REQ-025 key[0] low for 10 cycles, then high -> exactly one invert toggle; leds=10'h15A (invert flag bit 8 set); the release makes no change.
REQ-026 key[0] bounce 0/1/0 each held 2 cycles, then held low -> the event fires only after 4 stable cycles; exactly one event.
REQ-027 switch[8]=1, key[1] press from index 0 -> index 3 (wrap); switch[8]=0, press -> index 0.
REQ-028 key[0] and key[1] debounced presses in the same cycle -> invert and index both update on the following cycle.
REQ-029 With DATE_DISPLAY_BLINK_EN, switch[9]=1 -> hex alternates all-8'hFF/date every 8 cycles and leds[9] tracks the phase; assert reset mid-period -> phase 0, counter restarts.
